capture_ctrl: RTL and testbench

Sequences sample capture into the three channel trace RAMs. It generates the write-side controls consumed by the RAM interface: `we`, `cap_en`, `cap_addr` and `trace_end`. It decimates the sample clock, fills a circular buffer, and qualifies the trigger so the requested number of pre-trigger samples is present. It then stops after the programmed post-trigger count and flags completion for the command/dump logic.

---
 rtl/capture_if.sv | 29 ++
 rtl/capture_ctrl.sv | 110 +++++++++++
 tb/tb_capture_ctrl.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/capture_if.sv
// Capture command/status bundle between the command logic and capture_ctrl.
// master drives commands and reads status; slave is the capture sequencer.
interface capture_if #(
  parameter int AW = 9
);
  logic          cap_start;
  logic          cap_abort;
  logic          trig_event;
  logic [AW-1:0] trig_pos;
  logic [3:0]    dec_pwr;
  logic          clr_cap_done;
  logic          we;
  logic          cap_en;
  logic [AW-1:0] cap_addr;
  logic [AW-1:0] trace_end;
  logic          armed;
  logic          triggered;
  logic          capture_done;

  modport master (
    output cap_start, cap_abort, trig_event, trig_pos, dec_pwr, clr_cap_done,
    input  we, cap_en, cap_addr, trace_end, armed, triggered, capture_done
  );

  modport slave (
    input  cap_start, cap_abort, trig_event, trig_pos, dec_pwr, clr_cap_done,
    output we, cap_en, cap_addr, trace_end, armed, triggered, capture_done
  );
endinterface

// File: rtl/capture_ctrl.sv
// Capture sequencer: decimated circular-buffer writes into the trace RAMs,
// trigger qualification against the pre-trigger fill, and post-trigger stop.
module capture_ctrl #(
  parameter int DEPTH = 384,
  parameter int AW    = 9
) (
  input logic      clk,
  input logic      rst_n,
  capture_if.slave bus
);
  typedef enum logic [1:0] {IDLE, PRE, POST, DONE} state_t;

  localparam int            CW      = AW + 2;
  localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);
  localparam logic [AW-1:0] ONE_A   = AW'(1);
  localparam logic [AW:0]   DEPTH_S = (AW+1)'(DEPTH);
  localparam logic [AW:0]   ONE_S   = (AW+1)'(1);

  state_t        state_q, state_d;
  logic [AW-1:0] tp_q, wptr_q, pcnt_q, trace_end_q;
  logic [AW:0]   scnt_q;
  logic [3:0]    dp_q;
  logic [15:0]   dcnt_q, dec_mask;
  logic          triggered_q, done_q;
  logic          we, tick, wr, armed, abort, trig_ok, post_last;

  assign dec_mask  = ~(16'hFFFF << dp_q);
  assign tick      = (dcnt_q == dec_mask);
  assign we        = (state_q == PRE) || (state_q == POST);
  assign abort     = we && bus.cap_abort;
  // An abort in the same cycle as a tick suppresses the bookkeeping for that write.
  assign wr        = we && tick && !bus.cap_abort;
  // Widened sum avoids the underflow DEPTH - tp would need.
  assign armed     = (state_q == PRE) && ((CW'(scnt_q) + CW'(tp_q)) >= CW'(DEPTH));
  assign trig_ok   = (state_q == PRE) && bus.trig_event && armed && !bus.cap_abort;
  assign post_last = (state_q == POST) && wr && ((pcnt_q + ONE_A) == tp_q);

  // NOTE: always_ff uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: next state gets a default before the case so no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (bus.cap_start) state_d = PRE;
      PRE: begin
        if (abort)        state_d = IDLE;
        else if (trig_ok) state_d = (tp_q == '0) ? DONE : POST;
      end
      POST: begin
        if (abort)          state_d = IDLE;
        else if (post_last) state_d = DONE;
      end
      DONE: if (bus.clr_cap_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tp_q        <= '0;
      dp_q        <= '0;
      dcnt_q      <= '0;
      wptr_q      <= '0;
      scnt_q      <= '0;
      pcnt_q      <= '0;
      trace_end_q <= '0;
      triggered_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      if ((state_q == IDLE) && bus.cap_start) begin
        tp_q   <= (bus.trig_pos > LAST) ? LAST : bus.trig_pos;
        dp_q   <= bus.dec_pwr;
        dcnt_q <= '0;
        wptr_q <= '0;
        scnt_q <= '0;
        pcnt_q <= '0;
      end
      if (we && !bus.cap_abort) dcnt_q <= tick ? '0 : dcnt_q + 16'd1;
      if (wr) begin
        wptr_q      <= (wptr_q == LAST) ? '0 : wptr_q + ONE_A;
        trace_end_q <= wptr_q;
        if ((state_q == PRE) && (scnt_q != DEPTH_S)) scnt_q <= scnt_q + ONE_S;
        if (state_q == POST) pcnt_q <= pcnt_q + ONE_A;
      end
      if (trig_ok) begin
        triggered_q <= 1'b1;
        pcnt_q      <= '0;
      end
      if (abort) triggered_q <= 1'b0;
      if (we && (state_d == DONE)) done_q <= 1'b1;
      if ((state_q == DONE) && bus.clr_cap_done) begin
        triggered_q <= 1'b0;
        done_q      <= 1'b0;
      end
    end
  end

  assign bus.we           = we;
  assign bus.cap_en       = we && tick;
  assign bus.cap_addr     = wptr_q;
  assign bus.trace_end    = trace_end_q;
  assign bus.armed        = armed;
  assign bus.triggered    = triggered_q;
  assign bus.capture_done = done_q;
endmodule

// File: tb/tb_capture_ctrl.sv
// Directed bench for capture_ctrl: basic capture, early trigger, decimation and
// wrap, abort/restart, zero post-trigger, trig_pos clamping and async reset.
module tb_capture_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  capture_if #(.AW(9)) bus ();
  capture_ctrl #(.DEPTH(384), .AW(9)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_cap(input logic [8:0] tp, input logic [3:0] dp);
    bus.trig_pos  = tp;
    bus.dec_pwr   = dp;
    bus.cap_start = 1'b1;
    step();
    bus.cap_start = 1'b0;
  endtask

  task automatic pulse_trig();
    bus.trig_event = 1'b1;
    step();
    bus.trig_event = 1'b0;
  endtask

  task automatic pulse_clr();
    bus.clr_cap_done = 1'b1;
    step();
    bus.clr_cap_done = 1'b0;
  endtask

  function automatic logic [31:0] all_outs();
    return {bus.we, bus.cap_en, bus.cap_addr, bus.trace_end,
            bus.armed, bus.triggered, bus.capture_done};
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad_gap;
    int bad_addr;
    bus.cap_start    = 1'b0;
    bus.cap_abort    = 1'b0;
    bus.trig_event   = 1'b0;
    bus.trig_pos     = '0;
    bus.dec_pwr      = '0;
    bus.clr_cap_done = 1'b0;

    #3;
    check("reset_outputs", all_outs(), 32'd0);
    #9 rst_n = 1'b1;
    step();
    check("idle_we", bus.we, 0);

    // Basic capture with an early (ignored) trigger: tp=128, dec_pwr=0.
    start_cap(9'd128, 4'd0);
    check("basic_we", bus.we, 1);
    check("basic_first_en", bus.cap_en, 1);
    check("basic_first_addr", bus.cap_addr, 0);
    check("basic_armed0", bus.armed, 0);
    repeat (100) step();
    check("early_addr", bus.cap_addr, 100);
    pulse_trig();
    check("early_trig_ignored", bus.triggered, 0);
    check("early_still_pre", bus.we, 1);
    repeat (154) step();
    check("armed_before_256", bus.armed, 0);
    step();
    check("armed_after_256", bus.armed, 1);
    repeat (43) step();
    check("trig_addr", bus.cap_addr, 299);
    pulse_trig();
    check("triggered_set", bus.triggered, 1);
    check("first_post_addr", bus.cap_addr, 300);
    repeat (127) step();
    check("last_post_addr", bus.cap_addr, 43);
    check("last_post_en", bus.cap_en, 1);
    check("not_done_yet", bus.capture_done, 0);
    step();
    check("basic_done", bus.capture_done, 1);
    check("done_we", bus.we, 0);
    check("done_cap_en", bus.cap_en, 0);
    check("basic_trace_end", bus.trace_end, 43);
    bus.cap_start = 1'b1;
    step();
    bus.cap_start = 1'b0;
    repeat (2) step();
    check("done_hold", bus.capture_done, 1);
    check("done_start_ignored", bus.we, 0);
    check("done_trace_hold", bus.trace_end, 43);
    pulse_clr();
    check("clr_done", bus.capture_done, 0);
    check("clr_triggered", bus.triggered, 0);

    // Decimation by 8 with address wrap, then abort in POST on a tick.
    start_cap(9'd5, 4'd3);
    repeat (6) step();
    check("dec_no_early_en", bus.cap_en, 0);
    step();
    check("dec_first_en", bus.cap_en, 1);
    check("dec_first_addr", bus.cap_addr, 0);
    bad_gap  = 0;
    bad_addr = 0;
    for (int k = 1; k < 400; k++) begin
      repeat (7) begin
        step();
        if (bus.cap_en !== 1'b0) bad_gap++;
      end
      step();
      if (bus.cap_en !== 1'b1) bad_gap++;
      if (bus.cap_addr !== 9'(k % 384)) bad_addr++;
      if (k == 383) check("dec_addr_383", bus.cap_addr, 383);
      if (k == 384) check("dec_wrap_0", bus.cap_addr, 0);
    end
    check("dec_spacing_errors", bad_gap, 0);
    check("dec_addr_errors", bad_addr, 0);
    pulse_trig();
    check("dec_triggered", bus.triggered, 1);
    check("dec_trace_end", bus.trace_end, 15);
    repeat (7) step();
    check("post_tick_en", bus.cap_en, 1);
    check("post_tick_addr", bus.cap_addr, 16);
    bus.cap_abort = 1'b1;
    step();
    bus.cap_abort = 1'b0;
    check("abort_we", bus.we, 0);
    check("abort_cap_en", bus.cap_en, 0);
    check("abort_triggered", bus.triggered, 0);
    check("abort_done", bus.capture_done, 0);
    check("abort_trace_end", bus.trace_end, 15);
    repeat (3) step();
    check("abort_idle_done", bus.capture_done, 0);

    // Restart with tp=0; trigger coincides with the 400th write.
    start_cap(9'd0, 4'd0);
    check("restart_addr", bus.cap_addr, 0);
    check("restart_en", bus.cap_en, 1);
    repeat (383) step();
    check("tp0_armed_383", bus.armed, 0);
    step();
    check("tp0_armed_384", bus.armed, 1);
    repeat (15) step();
    check("tp0_trig_addr", bus.cap_addr, 15);
    check("tp0_trig_en", bus.cap_en, 1);
    pulse_trig();
    check("tp0_done", bus.capture_done, 1);
    check("tp0_we", bus.we, 0);
    check("tp0_trace_end", bus.trace_end, 15);
    check("tp0_triggered", bus.triggered, 1);
    pulse_clr();

    // trig_pos=500 clamps to 383: armed after one write, 383 post writes.
    start_cap(9'd500, 4'd0);
    check("clamp_armed0", bus.armed, 0);
    step();
    check("clamp_armed1", bus.armed, 1);
    pulse_trig();
    check("clamp_triggered", bus.triggered, 1);
    repeat (382) step();
    check("clamp_last_addr", bus.cap_addr, 0);
    check("clamp_not_done", bus.capture_done, 0);
    step();
    check("clamp_done", bus.capture_done, 1);
    check("clamp_trace_end", bus.trace_end, 0);
    pulse_clr();

    // Asynchronous reset in the middle of PRE.
    start_cap(9'd128, 4'd0);
    repeat (300) step();
    check("pre_reset_armed", bus.armed, 1);
    check("pre_reset_trace_end", bus.trace_end, 299);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_outputs", all_outs(), 32'd0);
    #8 rst_n = 1'b1;
    step();
    check("post_reset_idle", bus.we, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
